// File: rtl/snax_hwpe_periph_pkg.sv
// rtl/snax_hwpe_periph_pkg.sv - register map, status bits and FSM states for the periph responder
package snax_hwpe_periph_pkg;

    localparam logic [7:0] REG_TRIGGER  = 8'h00;
    localparam logic [7:0] REG_STATUS   = 8'h04;
    localparam logic [7:0] REG_CLEAR    = 8'h08;
    localparam logic [7:0] REG_JOB_CNT  = 8'h0C;
    localparam logic [7:0] REG_IRQ_EN   = 8'h10;
    localparam logic [7:0] REG_CFG_BASE = 8'h20;

    localparam int unsigned CFG_BASE_IDX = 32'(REG_CFG_BASE) >> 2;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;
    localparam int unsigned STATUS_ERR_BIT  = 2;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        BUSY
    } state_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TRIGGER,
        SEL_STATUS,
        SEL_CLEAR,
        SEL_JOB_CNT,
        SEL_IRQ_EN,
        SEL_CFG
    } reg_sel_e;

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// rtl/hwpe_ctrl_intf_periph.sv - HWPE peripheral control bus (req/gnt request, r_valid response)
interface hwpe_ctrl_intf_periph #(
    parameter int unsigned ID_WIDTH = 5
);
    logic                req;
    logic                gnt;
    logic [31:0]         add;
    logic                wen;
    logic [3:0]          be;
    logic [31:0]         data;
    logic [ID_WIDTH-1:0] id;
    logic [31:0]         r_data;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );
endinterface

// File: rtl/snax_hwpe_periph_decode.sv
// rtl/snax_hwpe_periph_decode.sv - combinational address to register select with unmapped flag
module snax_hwpe_periph_decode
    import snax_hwpe_periph_pkg::*;
#(
    parameter int unsigned NumCfgRegs = 8,
    parameter bit          IrqEn      = 1'b0
) (
    input  logic [31:0] add,
    output reg_sel_e    sel,
    output logic [4:0]  cfg_idx,
    output logic        unmapped
);

    logic [5:0] idx;

    always_comb begin
        sel     = SEL_NONE;
        cfg_idx = '0;
        idx     = add[7:2];
        if (add[31:8] == '0 && add[1:0] == 2'b00) begin
            case (add[7:0])
                REG_TRIGGER: sel = SEL_TRIGGER;
                REG_STATUS:  sel = SEL_STATUS;
                REG_CLEAR:   sel = SEL_CLEAR;
                REG_JOB_CNT: sel = SEL_JOB_CNT;
                REG_IRQ_EN:  if (IrqEn) sel = SEL_IRQ_EN;
                default: begin
                    // below-base offsets wrap to huge values and fail the range test
                    if ({26'd0, idx} - CFG_BASE_IDX < NumCfgRegs) begin
                        sel     = SEL_CFG;
                        cfg_idx = 5'(idx - 6'(CFG_BASE_IDX));
                    end
                end
            endcase
        end
    end

    assign unmapped = (sel == SEL_NONE);

endmodule

// File: rtl/snax_hwpe_periph_regfile.sv
// rtl/snax_hwpe_periph_regfile.sv - periph responder: job config registers, start handshake, status
// Optional interrupt output and IRQ_EN register under SNAX_HWPE_PERIPH_IRQ_EN.
module snax_hwpe_periph_regfile
    import snax_hwpe_periph_pkg::*;
#(
    parameter int unsigned NumCfgRegs = 8,
    parameter int unsigned IdWidth    = 5,
    parameter int unsigned DataWidth  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    hwpe_ctrl_intf_periph.slave      periph,
    output logic [NumCfgRegs*32-1:0] cfg_o,
    output logic                     start_valid_o,
    input  logic                     start_ready_i,
    input  logic                     done_i,
`ifdef SNAX_HWPE_PERIPH_IRQ_EN
    output logic                     irq_o,
`endif
    output logic                     busy_o
);

    if (DataWidth != 32) begin : gen_bad_data_width
        $error("snax_hwpe_periph_regfile: DataWidth must be 32");
    end
    if (NumCfgRegs < 1 || NumCfgRegs > 24) begin : gen_bad_num_cfg
        $error("snax_hwpe_periph_regfile: NumCfgRegs must be 1..24");
    end

`ifdef SNAX_HWPE_PERIPH_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif

    reg_sel_e   sel;
    logic [4:0] cfg_idx;
    logic       unmapped;

    snax_hwpe_periph_decode #(
        .NumCfgRegs (NumCfgRegs),
        .IrqEn      (IrqEn)
    ) i_decode (
        .add      (periph.add),
        .sel      (sel),
        .cfg_idx  (cfg_idx),
        .unmapped (unmapped)
    );

    state_e state_q, state_d;
    logic [NumCfgRegs*32-1:0] cfg_q;
    logic        done_q, done_d, err_q, err_d, irq_en_q;
    logic [31:0] job_cnt_q, rd_val, cfg_rd;
    logic        r_valid_q;
    logic [IdWidth-1:0] r_id_q;
    logic [31:0] r_data_q;

    logic wr_ok, be_any, trig_wr, clear_wr, cfg_wr, job_done, busy_err, idle;

    assign idle     = (state_q == IDLE);
    assign be_any   = |periph.be;
    assign wr_ok    = periph.req & ~periph.wen & ~unmapped & be_any;
    assign trig_wr  = wr_ok & (sel == SEL_TRIGGER);
    assign clear_wr = wr_ok & (sel == SEL_CLEAR);
    assign cfg_wr   = wr_ok & (sel == SEL_CFG);
    assign job_done = (state_q == BUSY) & done_i;
    assign busy_err = ~idle & (trig_wr | cfg_wr);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trig_wr) state_d = LAUNCH;
            LAUNCH:  if (start_ready_i) state_d = BUSY;
            BUSY:    if (done_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign start_valid_o = (state_q == LAUNCH);
    assign busy_o        = ~idle;

    // set beats clear for both sticky flags
    always_comb begin
        done_d = done_q;
        err_d  = err_q;
        if (clear_wr || (trig_wr && idle)) done_d = 1'b0;
        if (job_done)                      done_d = 1'b1;
        if (clear_wr)                      err_d  = 1'b0;
        if (busy_err)                      err_d  = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            job_cnt_q <= '0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
            if (job_done) job_cnt_q <= job_cnt_q + 32'd1;
            for (int i = 0; i < NumCfgRegs; i++) begin
                for (int k = 0; k < 4; k++) begin
                    if (cfg_wr && idle && cfg_idx == 5'(i) && periph.be[k])
                        cfg_q[32*i+8*k +: 8] <= periph.data[8*k +: 8];
                end
            end
        end
    end

    assign cfg_o = cfg_q;

`ifdef SNAX_HWPE_PERIPH_IRQ_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_q <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            if (wr_ok && sel == SEL_IRQ_EN && periph.be[0]) irq_en_q <= periph.data[0];
            irq_o <= irq_en_q & done_d;
        end
    end
`else
    assign irq_en_q = 1'b0;
`endif

    always_comb begin
        cfg_rd = '0;
        for (int i = 0; i < NumCfgRegs; i++) begin
            if (cfg_idx == 5'(i)) cfg_rd = cfg_q[32*i +: 32];
        end
        rd_val = '0;
        case (sel)
            SEL_STATUS: begin
                rd_val[STATUS_BUSY_BIT] = ~idle;
                rd_val[STATUS_DONE_BIT] = done_q;
                rd_val[STATUS_ERR_BIT]  = err_q;
            end
            SEL_JOB_CNT: rd_val = job_cnt_q;
            SEL_IRQ_EN:  rd_val = {31'd0, irq_en_q};
            SEL_CFG:     rd_val = cfg_rd;
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= periph.req;
            if (periph.req) begin
                r_id_q   <= periph.id;
                r_data_q <= periph.wen ? rd_val : 32'd0;
            end
        end
    end

    assign periph.gnt     = periph.req;
    assign periph.r_valid = r_valid_q;
    assign periph.r_id    = r_id_q;
    assign periph.r_data  = r_data_q;

endmodule

// File: tb/tb_snax_hwpe_periph_regfile.sv
// tb/tb_snax_hwpe_periph_regfile.sv - scoreboard bench with a behavioural register-map model
module tb_snax_hwpe_periph_regfile;

    localparam int N   = 8;
    localparam int IDW = 5;
    localparam int PH_IDLE = 0, PH_WAIT_START = 1, PH_RUNNING = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hwpe_ctrl_intf_periph #(.ID_WIDTH(IDW)) periph ();
    logic [N*32-1:0] cfg_o;
    logic start_valid, start_ready, done, busy;
`ifdef SNAX_HWPE_PERIPH_IRQ_EN
    logic irq;
`endif

    snax_hwpe_periph_regfile #(
        .NumCfgRegs (N),
        .IdWidth    (IDW),
        .DataWidth  (32)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .periph        (periph),
        .cfg_o         (cfg_o),
        .start_valid_o (start_valid),
        .start_ready_i (start_ready),
        .done_i        (done),
`ifdef SNAX_HWPE_PERIPH_IRQ_EN
        .irq_o         (irq),
`endif
        .busy_o        (busy)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0]    data;
        logic [IDW-1:0] id;
    } exp_t;
    exp_t sb[$];

    logic [31:0] m_cfg [N];
    int          m_phase;
    bit          m_done, m_err, m_irq_en, m_irq;
    logic [31:0] m_cnt;
    bit          g_sr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cfg[i] = '0;
        m_phase = PH_IDLE; m_done = 0; m_err = 0; m_irq_en = 0; m_irq = 0; m_cnt = '0;
    endtask

    function automatic bit on_map(input logic [31:0] a);
        return (a >> 8) == 0 && (a % 4) == 0;
    endfunction

    function automatic int cfg_slot(input logic [31:0] a);
        if (on_map(a) && a >= 32'h20 && (a - 32'h20) / 4 < N) return int'((a - 32'h20) / 4);
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int s = cfg_slot(a);
        if (s >= 0) return m_cfg[s];
        if (!on_map(a)) return 0;
        if (a == 32'h04) return {29'd0, m_err, m_done, m_phase != PH_IDLE};
        if (a == 32'h0C) return m_cnt;
`ifdef SNAX_HWPE_PERIPH_IRQ_EN
        if (a == 32'h10) return {31'd0, m_irq_en};
`endif
        return 0;
    endfunction

    task automatic model_step(input bit req, input bit wen, input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] d, input bit sr, input bit dn);
        bit w    = req && !wen && be != 0;
        int s    = cfg_slot(a);
        bit trig = w && on_map(a) && a == 0;
        bit clr  = w && on_map(a) && a == 8;
        bit cfgw = w && s >= 0;
        bit jd   = (m_phase == PH_RUNNING) && dn;
        bit ndone = m_done;
        bit nirq_en = m_irq_en;
        if (m_phase != PH_IDLE && (trig || cfgw)) m_err = 1;
        else if (clr) m_err = 0;
        if (jd) ndone = 1;
        else if (clr || (trig && m_phase == PH_IDLE)) ndone = 0;
        if (m_phase == PH_IDLE && cfgw)
            for (int k = 0; k < 4; k++) if (be[k]) m_cfg[s][8*k +: 8] = d[8*k +: 8];
`ifdef SNAX_HWPE_PERIPH_IRQ_EN
        if (req && !wen && a == 32'h10 && be[0]) nirq_en = d[0];
`endif
        m_irq = m_irq_en && ndone;
        m_irq_en = nirq_en;
        m_done = ndone;
        if (jd) m_cnt = m_cnt + 1;
        case (m_phase)
            PH_IDLE:       if (trig) m_phase = PH_WAIT_START;
            PH_WAIT_START: if (sr) m_phase = PH_RUNNING;
            default:       if (dn) m_phase = PH_IDLE;
        endcase
    endtask

    // One bus cycle; use_exp replaces the model's read value with a hand-derived constant.
    task automatic cycle(input bit req, input bit wen, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, input logic [IDW-1:0] id, input bit dn,
                         input bit use_exp, input logic [31:0] exp);
        logic [N*32-1:0] ecfg;
        @(negedge clk);
        for (int i = 0; i < N; i++) ecfg[32*i +: 32] = m_cfg[i];
        tests++;
        if (cfg_o !== ecfg) begin
            fails++;
            $display("FAIL cfg_o: got %h expected %h", cfg_o, ecfg);
        end
        check("start_valid_o", {31'd0, start_valid}, {31'd0, m_phase == PH_WAIT_START});
        check("busy_o", {31'd0, busy}, {31'd0, m_phase != PH_IDLE});
`ifdef SNAX_HWPE_PERIPH_IRQ_EN
        check("irq_o", {31'd0, irq}, {31'd0, m_irq});
`endif
        periph.req = req; periph.wen = wen; periph.add = a; periph.be = be;
        periph.data = d; periph.id = id; start_ready = g_sr; done = dn;
        #1;
        check("gnt", {31'd0, periph.gnt}, {31'd0, req});
        if (req) begin
            exp_t e;
            e.data = (!wen) ? 32'd0 : (use_exp ? exp : model_read(a));
            e.id   = id;
            sb.push_back(e);
        end
        model_step(req, wen, a, be, d, g_sr, dn);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        cycle(1, 0, a, be, d, 5'($urandom), 0, 0, 0);
    endtask
    task automatic rdx(input logic [31:0] a, input logic [31:0] exp);
        cycle(1, 1, a, 4'hF, 32'($urandom), 5'($urandom), 0, 1, exp);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic done_pulse();
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("r_valid", {31'd0, periph.r_valid}, 32'd1);
                    check("r_data", periph.r_data, e.data);
                    check("r_id", {27'd0, periph.r_id}, {27'd0, e.id});
                end else if (periph.r_valid) begin
                    tests++; fails++;
                    $display("FAIL r_valid_spurious: got 1 expected 0 at %0t", $time);
                end
            end
        end
    end

    initial begin : stim
        model_reset();
        periph.req = 0; periph.wen = 0; periph.add = 0; periph.be = 0;
        periph.data = 0; periph.id = 0; start_ready = 0; done = 0;
        #12;
        check("reset_gnt", {31'd0, periph.gnt}, 0);
        check("reset_r_valid", {31'd0, periph.r_valid}, 0);
        check("reset_start_valid", {31'd0, start_valid}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        @(negedge clk); #2 rst_n = 1;

        // full-word write then back-to-back read
        cycle(1, 0, 32'h28, 4'hF, 32'h12345678, 5'd3, 0, 0, 0);
        cycle(1, 1, 32'h28, 4'hF, 0, 5'd7, 0, 1, 32'h12345678);
        wr(32'h20, 32'hAABBCCDD, 4'h5);
        rdx(32'h20, 32'h00BB00DD);

        // job with a slow start acceptance
        g_sr = 0;
        wr(32'h00, 32'h1, 4'hF);
        idle(3);
        g_sr = 1; idle(1); g_sr = 0;
        rdx(32'h04, 32'h1);
        done_pulse();
        rdx(32'h04, 32'h2);
        rdx(32'h0C, 32'h1);
        wr(32'h08, 32'h1, 4'hF);
        rdx(32'h04, 32'h0);

        // config write during a job is rejected and flagged
        g_sr = 1;
        wr(32'h00, 32'h1, 4'h1);
        idle(1);
        wr(32'h24, 32'hDEADBEEF, 4'hF);
        rdx(32'h04, 32'h5);
        rdx(32'h24, 32'h0);
        // trigger coinciding with done: dropped, err, back to idle
        cycle(1, 0, 32'h00, 4'hF, 1, 0, 1, 0, 0);
        rdx(32'h04, 32'h6);
        idle(2);
        rdx(32'h0C, 32'h2);
        wr(32'h08, 32'h1, 4'hF);

        // clear coinciding with done keeps done; trigger clears done
        wr(32'h00, 32'h1, 4'hF);
        idle(1);
        cycle(1, 0, 32'h08, 4'hF, 1, 0, 1, 0, 0);
        rdx(32'h04, 32'h2);
        g_sr = 0;
        wr(32'h00, 32'h1, 4'hF);
        rdx(32'h04, 32'h1);
        g_sr = 1; idle(1);
        done_pulse();
        wr(32'h08, 32'h1, 4'hF);

        // unmapped, write-only and read-only handling, be=0, last slot
        wr(32'h104, 32'hFFFFFFFF, 4'hF);
        rdx(32'h100, 32'h0);
        rdx(32'h22, 32'h0);
        rdx(32'h00, 32'h0);
        rdx(32'h08, 32'h0);
        wr(32'h04, 32'hFFFFFFFF, 4'hF);
        rdx(32'h04, 32'h0);
        wr(32'h2C, 32'hFFFFFFFF, 4'h0);
        rdx(32'h2C, 32'h0);
        wr(32'h3C, 32'hCAFEF00D, 4'hF);
        rdx(32'h3C, 32'hCAFEF00D);
        wr(32'h40, 32'h11111111, 4'hF);
        rdx(32'h40, 32'h0);
`ifdef SNAX_HWPE_PERIPH_IRQ_EN
        wr(32'h10, 32'h1, 4'hF);
        rdx(32'h10, 32'h1);
        wr(32'h00, 32'h1, 4'hF);
        idle(1);
        done_pulse();
        idle(1);
        check("irq_after_done", {31'd0, irq}, 1);
        wr(32'h08, 32'h1, 4'hF);
        idle(1);
        check("irq_after_clear", {31'd0, irq}, 0);
`else
        rdx(32'h10, 32'h0);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            int pick = $urandom_range(0, 9);
            case (pick)
                0: a = 32'h00; 1: a = 32'h04; 2: a = 32'h08; 3: a = 32'h0C; 4: a = 32'h10;
                5: a = 32'h22; 6: a = 32'h100;
                default: a = 32'h20 + 4 * $urandom_range(0, N + 1);
            endcase
            g_sr = ($urandom_range(0, 1) == 1);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, 4'($urandom),
                  $urandom, 5'($urandom), $urandom_range(0, 7) == 0, 0, 0);
        end

        // reset in the middle of a launch loses the pending response
        idle(2);
        g_sr = 0;
        wr(32'h08, 32'h1, 4'hF);
        wr(32'h00, 32'h1, 4'hF);
        cycle(1, 1, 32'h04, 4'hF, 0, 5'd9, 0, 1, 32'h1);
        #1;
        periph.req = 0;
        rst_n = 0;
        sb.delete();
        model_reset();
        #1;
        check("reset_drops_start_valid", {31'd0, start_valid}, 0);
        check("reset_drops_busy", {31'd0, busy}, 0);
        @(negedge clk);
        check("reset_r_valid_lost", {31'd0, periph.r_valid}, 0);
        #2 rst_n = 1;
        rdx(32'h04, 32'h0);
        rdx(32'h0C, 32'h0);
        idle(3);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
